// File: rtl/ahblite_sram_slave_if.sv
`default_nettype none
// ============================================================================
// ahblite_sram_slave_if : AHB-Lite slave-side bus signals for the SRAM bridge
// Revision: 1.0
// ============================================================================
interface ahblite_sram_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  hsel_i;
    logic [ADDR_WIDTH-5:0] haddr_i;
    logic [2:0]            hburst_i;
    logic                  hmastlock_i;
    logic [3:0]            hprot_i;
    logic [2:0]            hsize_i;
    logic [1:0]            htrans_i;
    logic [DATA_WIDTH-1:0] hwdata_i;
    logic                  hwrite_i;
    logic [DATA_WIDTH-1:0] hrdata_o;
    logic                  hready_o;
    logic                  hresp_o;

    modport master (
        output hsel_i, haddr_i, hburst_i, hmastlock_i, hprot_i,
               hsize_i, htrans_i, hwdata_i, hwrite_i,
        input  hrdata_o, hready_o, hresp_o
    );

    modport slave (
        input  hsel_i, haddr_i, hburst_i, hmastlock_i, hprot_i,
               hsize_i, htrans_i, hwdata_i, hwrite_i,
        output hrdata_o, hready_o, hresp_o
    );
endinterface
`default_nettype wire

// File: rtl/ahblite_sram_slave.sv
`default_nettype none
// ============================================================================
// ahblite_sram_slave : AHB-Lite slave bridging to a single-port 1-cycle SRAM
// Revision: 1.0
// ============================================================================
module ahblite_sram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 12
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_ni,
    ahblite_sram_slave_if.slave          ahb,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [MEM_AW-1:0]            sram_addr_o,
    output logic [DATA_WIDTH/8-1:0]      sram_be_o,
    output logic [DATA_WIDTH-1:0]        sram_wdata_o,
    input  wire logic [DATA_WIDTH-1:0]   sram_rdata_i
);
    localparam int BW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WRITE   = 3'd2,
        S_RD_WAIT = 3'd3,
        S_ERR1    = 3'd4,
        S_ERR2    = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [MEM_AW-1:0] lat_addr;
    logic [BW-1:0]     lat_be;

    logic              ready;
    logic              valid;
    logic              bad;
    logic              accept;
    logic [MEM_AW-1:0] cur_addr;
    logic [BW-1:0]     cur_be;

    wire unused_inputs = &{1'b0, ahb.hburst_i, ahb.hprot_i, ahb.hmastlock_i, ahb.htrans_i[0]};

    always_comb begin
        ready    = (state != S_RD_WAIT) && (state != S_ERR1);
        valid    = ready && ahb.hsel_i && ahb.htrans_i[1];
        bad      = (ahb.hsize_i > 3'd2)
                 || ((ahb.hsize_i == 3'd1) && ahb.haddr_i[0])
                 || ((ahb.hsize_i == 3'd2) && (ahb.haddr_i[1:0] != 2'b00))
                 || ((ahb.haddr_i >> (MEM_AW + 2)) != '0);
        accept   = valid && !bad;
        cur_addr = ahb.haddr_i[MEM_AW+1:2];
        case (ahb.hsize_i)
            3'd0:    cur_be = BW'(4'b0001) << ahb.haddr_i[1:0];
            3'd1:    cur_be = BW'(4'b0011) << ahb.haddr_i[1:0];
            default: cur_be = BW'(4'b1111);
        endcase
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_RD_WAIT: state_nxt = S_READ;
            S_ERR1:    state_nxt = S_ERR2;
            default: begin
                if (!valid)             state_nxt = S_IDLE;
                else if (bad)           state_nxt = S_ERR1;
                else if (ahb.hwrite_i)  state_nxt = S_WRITE;
                // SRAM port is busy with the write data phase: defer the read
                else if (state == S_WRITE) state_nxt = S_RD_WAIT;
                else                    state_nxt = S_READ;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            lat_addr <= '0;
            lat_be   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_addr <= cur_addr;
                lat_be   <= cur_be;
            end
        end
    end

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_be_o    = '0;
        sram_wdata_o = '0;
        case (state)
            S_WRITE: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = lat_addr;
                sram_be_o    = lat_be;
                sram_wdata_o = ahb.hwdata_i;
            end
            S_RD_WAIT: begin
                sram_req_o  = 1'b1;
                sram_addr_o = lat_addr;
                sram_be_o   = lat_be;
            end
            default: begin
                if (accept && !ahb.hwrite_i) begin
                    sram_req_o  = 1'b1;
                    sram_addr_o = cur_addr;
                    sram_be_o   = cur_be;
                end
            end
        endcase
        // The async reset must silence the strobe even before the state settles
        if (!rst_ni) begin
            sram_req_o = 1'b0;
            sram_we_o  = 1'b0;
        end
    end

    always_comb begin
        ahb.hready_o = ready;
        ahb.hresp_o  = (state == S_ERR1) || (state == S_ERR2);
        ahb.hrdata_o = (state == S_READ) ? sram_rdata_i : '0;
    end
endmodule
`default_nettype wire

// File: tb/tb_ahblite_sram_slave.sv
`default_nettype none
// ============================================================================
// tb_ahblite_sram_slave : directed self-checking bench for ahblite_sram_slave
// Revision: 1.0
// ============================================================================
module tb_ahblite_sram_slave;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MAW = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ahblite_sram_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic           sram_req, sram_we;
    logic [MAW-1:0] sram_addr;
    logic [3:0]     sram_be;
    logic [31:0]    sram_wdata;
    logic [31:0]    sram_rdata = '0;

    ahblite_sram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ahb          (bus.slave),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_be_o    (sram_be),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    logic [31:0] mem [0:(1<<MAW)-1];
    int checks = 0;
    int errors = 0;
    int wcount = 0;
    int wsnap;

    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                wcount <= wcount + 1;
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [27:0] addr, input logic [2:0] size);
        bus.hsel_i      = sel;
        bus.htrans_i    = trans;
        bus.hwrite_i    = wr;
        bus.haddr_i     = addr;
        bus.hsize_i     = size;
        bus.hburst_i    = 3'($urandom);
        bus.hprot_i     = 4'($urandom);
        bus.hmastlock_i = 1'($urandom);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 1'b0, 28'h0, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.hready_o !== 1'b1) begin errors++; $display("FAIL rst_hready got=%0b exp=1", bus.hready_o); end
        checks++; if (bus.hresp_o !== 1'b0) begin errors++; $display("FAIL rst_hresp got=%0b exp=0", bus.hresp_o); end
        checks++; if (bus.hrdata_o !== 32'h0) begin errors++; $display("FAIL rst_hrdata got=%0h exp=0", bus.hrdata_o); end
        checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0b exp=0", sram_req); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word_write_read();
        drive(1'b1, 2'b10, 1'b1, 28'h10, 3'd2);
        @(negedge clk);
        checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL ww_addr_phase_req got=%0b exp=0", sram_req); end
        tick();
        bus.hwdata_i = 32'hDEADBEEF;
        drive(1'b1, 2'b10, 1'b0, 28'h10, 3'd2);
        @(negedge clk);
        checks++; if ({sram_req, sram_we} !== 2'b11) begin errors++; $display("FAIL ww_strobe got=%b exp=11", {sram_req, sram_we}); end
        checks++; if (sram_addr !== 12'd4) begin errors++; $display("FAIL ww_addr got=%0h exp=4", sram_addr); end
        checks++; if (sram_be !== 4'hF) begin errors++; $display("FAIL ww_be got=%0h exp=f", sram_be); end
        checks++; if (sram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ww_wdata got=%0h exp=deadbeef", sram_wdata); end
        checks++; if (bus.hready_o !== 1'b1) begin errors++; $display("FAIL ww_hready got=%0b exp=1", bus.hready_o); end
        tick();
        idle();
        @(negedge clk);
        checks++; if ({bus.hready_o, bus.hresp_o} !== 2'b00) begin errors++; $display("FAIL rdwait_hready_hresp got=%b exp=00", {bus.hready_o, bus.hresp_o}); end
        checks++; if ({sram_req, sram_we, sram_addr} !== {2'b10, 12'd4}) begin errors++; $display("FAIL rdwait_sram got=%0h exp=%0h", {sram_req, sram_we, sram_addr}, {2'b10, 12'd4}); end
        tick();
        @(negedge clk);
        checks++; if (bus.hready_o !== 1'b1) begin errors++; $display("FAIL rd_hready got=%0b exp=1", bus.hready_o); end
        checks++; if (bus.hrdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%0h exp=deadbeef", bus.hrdata_o); end
        tick();
    endtask

    task automatic test_byte_write();
        drive(1'b1, 2'b10, 1'b1, 28'h13, 3'd0);
        tick();
        bus.hwdata_i = 32'hAA000000;
        idle();
        @(negedge clk);
        checks++; if ({sram_req, sram_we} !== 2'b11) begin errors++; $display("FAIL bw_strobe got=%b exp=11", {sram_req, sram_we}); end
        checks++; if (sram_be !== 4'b1000) begin errors++; $display("FAIL bw_be got=%b exp=1000", sram_be); end
        checks++; if (sram_addr !== 12'd4) begin errors++; $display("FAIL bw_addr got=%0h exp=4", sram_addr); end
        checks++; if (bus.hready_o !== 1'b1) begin errors++; $display("FAIL bw_hready got=%0b exp=1", bus.hready_o); end
        tick();
        drive(1'b1, 2'b10, 1'b0, 28'h10, 3'd2);
        tick();
        idle();
        @(negedge clk);
        checks++; if (bus.hrdata_o !== 32'hAAADBEEF) begin errors++; $display("FAIL bw_readback got=%0h exp=aaadbeef", bus.hrdata_o); end
        tick();
    endtask

    task automatic test_error_misaligned();
        drive(1'b1, 2'b10, 1'b0, 28'h01, 3'd1);
        @(negedge clk);
        checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL err_addr_req got=%0b exp=0", sram_req); end
        tick();
        idle();
        @(negedge clk);
        checks++; if ({bus.hready_o, bus.hresp_o, sram_req} !== 3'b010) begin errors++; $display("FAIL err1 got=%b exp=010", {bus.hready_o, bus.hresp_o, sram_req}); end
        tick();
        @(negedge clk);
        checks++; if ({bus.hready_o, bus.hresp_o, sram_req} !== 3'b110) begin errors++; $display("FAIL err2 got=%b exp=110", {bus.hready_o, bus.hresp_o, sram_req}); end
        tick();
        @(negedge clk);
        checks++; if ({bus.hready_o, bus.hresp_o} !== 2'b10) begin errors++; $display("FAIL err_after got=%b exp=10", {bus.hready_o, bus.hresp_o}); end
        tick();
    endtask

    task automatic test_error_range();
        wsnap = wcount;
        drive(1'b1, 2'b10, 1'b1, 28'h4000, 3'd2);
        tick();
        bus.hwdata_i = 32'h12345678;
        idle();
        @(negedge clk);
        checks++; if ({bus.hready_o, bus.hresp_o, sram_req} !== 3'b010) begin errors++; $display("FAIL rng_err1 got=%b exp=010", {bus.hready_o, bus.hresp_o, sram_req}); end
        tick();
        @(negedge clk);
        checks++; if ({bus.hready_o, bus.hresp_o} !== 2'b11) begin errors++; $display("FAIL rng_err2 got=%b exp=11", {bus.hready_o, bus.hresp_o}); end
        tick();
        checks++; if (wcount !== wsnap) begin errors++; $display("FAIL rng_nowrite got=%0d exp=%0d", wcount, wsnap); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333; mem[3] = 32'h44444444;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b0, 28'(4*i), 3'd2);
            else idle();
            @(negedge clk);
            if (i < 4) begin
                checks++; if ({sram_req, sram_we, sram_addr} !== {2'b10, 12'(i)}) begin errors++; $display("FAIL b2b_rd_issue%0d got=%0h exp=%0h", i, {sram_req, sram_we, sram_addr}, {2'b10, 12'(i)}); end
            end
            if (i > 0) begin
                checks++; if (bus.hready_o !== 1'b1) begin errors++; $display("FAIL b2b_rd_hready%0d got=%0b exp=1", i, bus.hready_o); end
                checks++; if (bus.hrdata_o !== exp_rd[i-1]) begin errors++; $display("FAIL b2b_rd_data%0d got=%0h exp=%0h", i, bus.hrdata_o, exp_rd[i-1]); end
            end
            tick();
        end
        drive(1'b1, 2'b10, 1'b1, 28'h20, 3'd2);
        tick();
        bus.hwdata_i = 32'hCAFE0001;
        drive(1'b1, 2'b11, 1'b1, 28'h24, 3'd2);
        @(negedge clk);
        checks++; if ({bus.hready_o, sram_req, sram_we, sram_addr, sram_wdata} !== {3'b111, 12'd8, 32'hCAFE0001}) begin errors++; $display("FAIL b2b_wr1 got=%0h exp=%0h", {bus.hready_o, sram_req, sram_we, sram_addr, sram_wdata}, {3'b111, 12'd8, 32'hCAFE0001}); end
        tick();
        bus.hwdata_i = 32'hCAFE0002;
        idle();
        @(negedge clk);
        checks++; if ({bus.hready_o, sram_req, sram_we, sram_addr, sram_wdata} !== {3'b111, 12'd9, 32'hCAFE0002}) begin errors++; $display("FAIL b2b_wr2 got=%0h exp=%0h", {bus.hready_o, sram_req, sram_we, sram_addr, sram_wdata}, {3'b111, 12'd9, 32'hCAFE0002}); end
        tick();
    endtask

    task automatic test_reset_mid_write();
        drive(1'b1, 2'b10, 1'b1, 28'h30, 3'd2);
        tick();
        bus.hwdata_i = 32'h55555555;
        idle();
        #1;
        checks++; if ({sram_req, sram_we} !== 2'b11) begin errors++; $display("FAIL rmw_pre got=%b exp=11", {sram_req, sram_we}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({sram_req, sram_we, bus.hready_o, bus.hresp_o} !== 4'b0010) begin errors++; $display("FAIL rmw_async got=%b exp=0010", {sram_req, sram_we, bus.hready_o, bus.hresp_o}); end
        wsnap = wcount;
        @(posedge clk);
        @(negedge clk);
        checks++; if (wcount !== wsnap || mem[12] !== 32'h0) begin errors++; $display("FAIL rmw_nowrite got=%0d/%0h exp=%0d/0", wcount, mem[12], wsnap); end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++; if ({bus.hready_o, bus.hresp_o, sram_req, bus.hrdata_o} !== {3'b100, 32'h0}) begin errors++; $display("FAIL rmw_idle got=%0h exp=%0h", {bus.hready_o, bus.hresp_o, sram_req, bus.hrdata_o}, {3'b100, 32'h0}); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << MAW); i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        bus.hwdata_i = 32'h0;
        idle();
        repeat (2) @(posedge clk);
        test_reset();
        test_word_write_read();
        test_byte_write();
        test_error_misaligned();
        test_error_range();
        test_back_to_back();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/ahblite_sram_slave.md
AHBLITE_SRAM_SLAVE -- requirements
Module: ahblite_sram_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AHB data bus width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, system address width; haddr_i is ADDR_WIDTH-4 bits.
REQ-003 SHALL have parameter MEM_AW, default 12, SRAM word-address width (2^MEM_AW words).
REQ-004 SHALL use one clock and an asynchronous, active-low reset:
  clk_i  in  1  clock, rising-edge
  rst_ni  in  1  asynchronous active-low reset
REQ-005 SHALL have the following AHB-Lite slave ports:
  hsel_i  in  1  slave select
  haddr_i  in  ADDR_WIDTH-4  byte address
  hburst_i  in  3  burst type (ignored)
  hmastlock_i  in  1  locked transfer (ignored)
  hprot_i  in  4  protection (ignored)
  hsize_i  in  3  transfer size
  htrans_i  in  2  transfer type
  hwdata_i  in  DATA_WIDTH  write data (data phase)
  hwrite_i  in  1  1=write
  hrdata_o  out  DATA_WIDTH  read data
  hready_o  out  1  transfer done / address phase accepted
  hresp_o  out  1  0=OKAY, 1=ERROR
REQ-006 SHALL have the following SRAM ports (single-port, 1-cycle read latency):
  sram_req_o  out  1  access strobe
  sram_we_o  out  1  1=write
  sram_addr_o  out  MEM_AW  word address
  sram_be_o  out  DATA_WIDTH/8  byte enables
  sram_wdata_o  out  DATA_WIDTH  write data
  sram_rdata_i  in  DATA_WIDTH  read data, valid the cycle after the read strobe

Function
REQ-007 SHALL sample an address phase only on a rising edge with hready_o=1; a transfer is valid when hsel_i=1 and htrans_i is NONSEQ (2'b10) or SEQ (2'b11).
REQ-008 SHALL treat IDLE/BUSY or hsel_i=0 as no transfer: next data phase has hready_o=1, hresp_o=0, zero wait states.
REQ-009 SHALL flag as error: hsize_i>2; hsize_i=1 with haddr_i[0]=1; hsize_i=2 with haddr_i[1:0]!=0; any nonzero haddr_i bit above bit MEM_AW+1.
REQ-010 SHALL answer an error transfer with a two-cycle ERROR response: ERR1 (hready_o=0, hresp_o=1), then ERR2 (hready_o=1, hresp_o=1); no SRAM access.
REQ-011 SHALL use word address haddr_i[MEM_AW+1:2]; byte enables: size0 = 4'b0001<<haddr[1:0], size1 = 4'b0011<<haddr[1:0], size2 = 4'b1111.
REQ-012 Read: SHALL assert sram_req_o=1, sram_we_o=0 combinationally in the accepted address-phase cycle; data phase (READ) has hready_o=1, hrdata_o=sram_rdata_i (zero wait states).
REQ-013 Write: SHALL latch address and byte enables in the address phase; in the data phase (WRITE) SHALL drive sram_req_o=1, sram_we_o=1, sram_wdata_o=hwdata_i, hready_o=1.
REQ-014 Write followed by write: the back-to-back address phase SHALL be latched during the WRITE cycle with no wait state.
REQ-015 Write followed by read (SRAM port conflict): the read address SHALL be latched in the WRITE cycle; the read is issued in RD_WAIT (hready_o=0, hresp_o=0); the next cycle is READ with data; exactly one wait state.
REQ-016 State machine: IDLE, READ, WRITE, RD_WAIT, ERR1, ERR2; READ/WRITE/IDLE/ERR2 transition per the address phase sampled that cycle; RD_WAIT->READ; ERR1->ERR2.
REQ-017 hrdata_o SHALL be 0 in every state other than READ; sram_req_o SHALL be 0 when no access is performed.
REQ-018 hburst_i, hprot_i and hmastlock_i SHALL have no effect on behaviour.

Reset
REQ-019 While rst_ni=0 (asynchronously): state=IDLE, hready_o=1, hresp_o=0, hrdata_o=0, sram_req_o=0, sram_we_o=0; latched address, byte enables and pending read SHALL clear.
REQ-020 Reset asserted mid-transfer SHALL abandon the transfer; no SRAM write SHALL occur after rst_ni falls.

Verification
REQ-021 Word write 0xDEADBEEF to 0x10, then read 0x10 -> sram write addr=4, be=4'hF; read returns 0xDEADBEEF after one wait state (RD_WAIT).
REQ-022 Byte write 0xAA to 0x13 (hwdata=0xAA000000) -> sram_be_o=4'b1000, addr=4, no wait state.
REQ-023 Halfword access at 0x01 -> ERR1 (hready=0, hresp=1), ERR2 (hready=1, hresp=1), sram_req_o never asserted.
REQ-024 Four back-to-back word reads at 0x0,0x4,0x8,0xC -> four consecutive hready_o=1 data phases, zero wait states.
REQ-025 Word write at 0x4000 with MEM_AW=12 -> ERROR response, no SRAM write.
REQ-026 rst_ni pulsed low during WRITE data phase -> sram_req_o=0 immediately, hready_o=1, hresp_o=0, state IDLE.
